// File: rtl/a2d_spi_pkg.sv
// Shared types and constants for the A2D SPI responder.
// Channel selection helper maps a 3-bit channel to its 12-bit slice of the flattened bus.
package a2d_spi_pkg;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  localparam int FRAME_BITS = 16;
  localparam int CHNL_MSB   = 13;
  localparam int CHNL_LSB   = 11;
  localparam int RES_W      = 12;
  localparam int NUM_CH     = 8;

  function automatic logic [RES_W-1:0] sel_ch(input logic [NUM_CH*RES_W-1:0] vals,
                                              input logic [2:0]              sel);
    logic [RES_W-1:0] r;
    r = {RES_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == i[2:0]) begin
        r = vals[i*RES_W +: RES_W];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/a2d_spi_resp_sync.sv
// Multi-flop synchronizer with rise/fall pulses computed on the synchronized signal.
// The edge history flop resets to the same value as the chain so reset never fakes an edge.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // synchronizer chain plus one flop of history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI mode-0 responder emulating an 8-channel 12-bit A2D: a 16-bit command frame selects
// the channel whose value is shifted out during the following frame. All SPI pins oversampled.
module a2d_spi_resp
  import a2d_spi_pkg::*;
#(
  parameter int FRAME_BITS_P = FRAME_BITS,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    SS_n,
  input  logic                    SCLK,
  input  logic                    MOSI,
  output logic                    MISO,
  input  logic [NUM_CH*RES_W-1:0] ch_vals,
  output logic [2:0]              chnnl_lat,
  output logic [15:0]             cmd,
  output logic                    frm_done,
  output logic                    frm_err
);

  logic ss_sync_s, ss_rise_s, ss_fall_s;
  logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
  logic mosi_sync_s, mosi_unused_rise_s, mosi_unused_fall_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d_i(SS_n),
    .q_o(ss_sync_s), .rise_o(ss_rise_s), .fall_o(ss_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(SCLK),
    .q_o(sclk_sync_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(MOSI),
    .q_o(mosi_sync_s), .rise_o(mosi_unused_rise_s), .fall_o(mosi_unused_fall_s)
  );

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic        ovf_q;
  logic [15:0] tx_shft_q;
  logic [15:0] rx_shft_q;
  logic        miso_q;
  logic [2:0]  chnnl_lat_q;
  logic [15:0] cmd_q;
  logic        frm_done_q;
  logic        frm_err_q;
  logic [3:0]  settle_q;
  logic        armed_q;
  logic        settled_s;
  logic [15:0] resp_s;

  // Until the chain has flushed real pin values, SS_n must be seen high before a frame may start
  assign settled_s = (settle_q >= 4'(SYNC_STAGES));
  assign resp_s    = {4'b0000, sel_ch(ch_vals, chnnl_lat_q)};

  // frame FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      ovf_q       <= 1'b0;
      tx_shft_q   <= 16'h0000;
      rx_shft_q   <= 16'h0000;
      miso_q      <= 1'b0;
      chnnl_lat_q <= 3'd0;
      cmd_q       <= 16'h0000;
      frm_done_q  <= 1'b0;
      frm_err_q   <= 1'b0;
      settle_q    <= 4'd0;
      armed_q     <= 1'b0;
    end else begin
      frm_done_q <= 1'b0;
      frm_err_q  <= 1'b0;
      if (!settled_s) begin
        settle_q <= settle_q + 4'd1;
      end
      if (settled_s && ss_sync_s) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall_s && armed_q) begin
            tx_shft_q <= resp_s;
            miso_q    <= resp_s[15];
            bit_cnt_q <= 5'd0;
            ovf_q     <= 1'b0;
            state_q   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_rise_s) begin
            if ((bit_cnt_q == 5'(FRAME_BITS_P)) && !ovf_q) begin
              cmd_q       <= rx_shft_q;
              chnnl_lat_q <= rx_shft_q[CHNL_MSB:CHNL_LSB];
              frm_done_q  <= 1'b1;
            end else begin
              frm_err_q <= 1'b1;
            end
            miso_q  <= 1'b0;
            state_q <= IDLE;
          end else if (sclk_rise_s) begin
            if (bit_cnt_q < 5'(FRAME_BITS_P)) begin
              rx_shft_q <= {rx_shft_q[14:0], mosi_sync_s};
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (sclk_fall_s) begin
            if (bit_cnt_q < 5'(FRAME_BITS_P)) begin
              tx_shft_q <= {tx_shft_q[14:0], 1'b0};
              miso_q    <= tx_shft_q[14];
            end
          end
        end
        default: begin
          miso_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MISO      = miso_q;
  assign chnnl_lat = chnnl_lat_q;
  assign cmd       = cmd_q;
  assign frm_done  = frm_done_q;
  assign frm_err   = frm_err_q;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Randomized + directed bench for a2d_spi_resp: a SPI master model issues frames, pushes the
// expected outcome into a queue, and a monitor checks each frm_done/frm_err pulse against it.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        SS_n, SCLK, MOSI, MISO;
  logic [95:0] ch_vals;
  logic [2:0]  chnnl_lat;
  logic [15:0] cmd;
  logic        frm_done, frm_err;

  always #5 clk = ~clk;

  a2d_spi_resp dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .ch_vals(ch_vals), .chnnl_lat(chnnl_lat), .cmd(cmd),
    .frm_done(frm_done), .frm_err(frm_err)
  );

  typedef struct {
    bit          is_done;
    logic [15:0] cmd;
    logic [2:0]  lat;
    logic [15:0] miso;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          pulses = 0;
  exp_t        expq[$];
  logic [11:0] m_ch[8];
  logic [2:0]  m_lat;
  logic [15:0] m_cmd;
  logic [15:0] cap_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive_ch();
    for (int i = 0; i < 8; i++) ch_vals[i*12 +: 12] = m_ch[i];
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one SCLK period: set MOSI, sample MISO just before the rising edge
  task automatic sclk_bit(input logic b, output logic s);
    MOSI = b;
    wait_clk(8);
    s = MISO;
    SCLK = 1'b1;
    wait_clk(8);
    SCLK = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] c, input int n, input int mid_ch, input logic [11:0] mid_val);
    logic [15:0] resp, w;
    logic        s;
    exp_t        e;
    int          nb;
    resp = {4'h0, m_ch[m_lat]};
    w = 16'h0000;
    SS_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      sclk_bit((i < 16) ? c[15-i] : 1'b0, s);
      if (i < 16) w = {w[14:0], s};
      if (i == 7 && mid_ch >= 0) begin
        m_ch[mid_ch] = mid_val;
        drive_ch();
      end
    end
    nb = (n < 16) ? n : 16;
    if (n == 16) begin
      m_cmd = c;
      m_lat = c[13:11];
    end
    e.is_done = (n == 16);
    e.cmd     = m_cmd;
    e.lat     = m_lat;
    e.miso    = resp >> (16 - nb);
    cap_word  = w;
    expq.push_back(e);
    wait_clk(4);
    SS_n = 1'b1;
    wait_clk(10);
  endtask

  // monitor: every completion/abort pulse is matched to the oldest expectation
  always @(negedge clk) begin
    if (rst_n && (frm_done || frm_err)) begin
      exp_t e;
      pulses++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none", frm_done, frm_err);
      end else begin
        e = expq.pop_front();
        check("done_flag", {31'd0, frm_done}, {31'd0, e.is_done});
        check("err_flag", {31'd0, frm_err}, {31'd0, ~e.is_done});
        check("cmd", {16'd0, cmd}, {16'd0, e.cmd});
        check("chnnl_lat", {29'd0, chnnl_lat}, {29'd0, e.lat});
        check("miso_word", {16'd0, cap_word}, {16'd0, e.miso});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s;
    int   p0, n;
    for (int i = 0; i < 8; i++) m_ch[i] = 12'h000;
    m_ch[0] = 12'h123;
    m_lat = 3'd0;
    m_cmd = 16'h0000;
    drive_ch();
    SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0; rst_n = 1'b0;
    wait_clk(3);
    check("rst_miso", {31'd0, MISO}, 32'd0);
    check("rst_lat", {29'd0, chnnl_lat}, 32'd0);
    check("rst_cmd", {16'd0, cmd}, 32'd0);
    check("rst_done", {31'd0, frm_done}, 32'd0);
    check("rst_err", {31'd0, frm_err}, 32'd0);
    rst_n = 1'b1;
    wait_clk(6);

    run_frame(16'h0000, 16, -1, 12'h000);
    m_ch[3] = 12'hABC; drive_ch();
    run_frame(16'h1800, 16, -1, 12'h000);
    run_frame(16'h1800, 16, -1, 12'h000);
    m_ch[7] = 12'hFFF; m_ch[2] = 12'h555; drive_ch();
    run_frame(16'h3800, 16, -1, 12'h000);
    run_frame(16'h1000, 16, -1, 12'h000);
    run_frame(16'h3800, 9, -1, 12'h000);
    run_frame(16'h1800, 16, -1, 12'h000);
    run_frame(16'h1800, 16, 3, 12'h001);
    run_frame(16'h0000, 16, -1, 12'h000);

    // reset in the middle of a frame, released while SS_n is still low
    p0 = pulses;
    SS_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 6; i++) sclk_bit(1'b1, s);
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst_miso", {31'd0, MISO}, 32'd0);
    check("midrst_lat", {29'd0, chnnl_lat}, 32'd0);
    check("midrst_cmd", {16'd0, cmd}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) sclk_bit(1'b1, s);
    check("ignored_miso", {31'd0, MISO}, 32'd0);
    wait_clk(4);
    SS_n = 1'b1;
    wait_clk(10);
    check("no_pulse_after_rst", pulses, p0);
    check("lat_after_rst", {29'd0, chnnl_lat}, 32'd0);
    m_lat = 3'd0;
    m_cmd = 16'h0000;
    run_frame(16'h2800, 16, -1, 12'h000);

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 8; i++) m_ch[i] = 12'($urandom);
      drive_ch();
      case ($urandom_range(0, 5))
        0:       n = $urandom_range(1, 15);
        1:       n = 17;
        default: n = 16;
      endcase
      run_frame(16'($urandom), n, -1, 12'h000);
    end

    wait_clk(20);
    check("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
